// File: rtl/onchip_arb_pkg.sv
// onchip_arb_pkg
//   Types and constants shared by the two-master on-chip RAM arbiter.
//   master_id_t : 1-bit master index (0 = m0, 1 = m1)
//   rd_tag_t    : {valid, id} entry of the read-return pipeline
//   RD_LAT      : accept-to-readdatavalid latency in cycles
// Build option: define ONCHIP_ARB_OUTREG_EN to register RAM read data
// before the master ports (RD_LAT = 2 instead of 1).
package onchip_arb_pkg;

  typedef logic [0:0] master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  typedef struct packed {
    logic       valid;
    master_id_t id;
  } rd_tag_t;

`ifdef ONCHIP_ARB_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/onchip_arb_rr_grant.sv
// onchip_arb_rr_grant
//   Combinational round-robin grant with a bounded hold, plus the
//   last_grant / hold_cnt state registers.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   req0_i/req1_i : master requests
//   gnt_valid_o   : a transfer is granted this cycle
//   gnt_id_o      : granted master (valid only with gnt_valid_o)
module onchip_arb_rr_grant
  import onchip_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_i,
  input  logic       req1_i,
  output logic       gnt_valid_o,
  output master_id_t gnt_id_o
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  master_id_t last_grant_q, last_grant_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       keep;

  always_comb begin
    gnt_valid_o  = req0_i | req1_i;
    gnt_id_o     = M0;
    last_grant_d = last_grant_q;
    hold_cnt_d   = hold_cnt_q;
    // hold_cnt == 0 only after reset: no hold in progress yet.
    keep = (hold_cnt_q != 4'd0) && (hold_cnt_q < HOLD_MAX);

    if (req0_i && req1_i) begin
      gnt_id_o = keep ? last_grant_q : ~last_grant_q;
    end else if (req1_i) begin
      gnt_id_o = M1;
    end

    if (gnt_valid_o) begin
      last_grant_d = gnt_id_o;
      if (gnt_id_o != last_grant_q) begin
        hold_cnt_d = 4'd1;
      end else if (hold_cnt_q < HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + 4'd1;
      end
    end
  end

  // last_grant resets to m1 so that m0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= M1;
      hold_cnt_q   <= 4'd0;
    end else begin
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// onchip_memory_arbiter
//   Shares one single-port on-chip RAM (s1) between two Avalon-MM masters.
//   One transfer per cycle, loser stalled with waitrequest, read data
//   steered back with readdatavalid.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   mN_address/byteenable/read/write/writedata : master N request
//   mN_waitrequest          : master N request not accepted this cycle
//   mN_readdata/readdatavalid : master N read return
//   mem_*                   : RAM s1 port (mem_clken tied high)
// Build option: ONCHIP_ARB_OUTREG_EN registers mem_readdata before the
// master ports, making the read latency 2 cycles instead of 1.
module onchip_memory_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic       req0, req1;
  logic       gnt_valid;
  master_id_t gnt_id;
  logic       gnt0, gnt1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  onchip_arb_rr_grant #(
    .MAX_HOLD (MAX_HOLD)
  ) u_grant (
    .clk         (clk),
    .reset       (reset),
    .req0_i      (req0),
    .req1_i      (req1),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  assign gnt0 = gnt_valid && (gnt_id == M0);
  assign gnt1 = gnt_valid && (gnt_id == M1);

  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;

  // Master 0's bus is the idle default so the RAM inputs do not toggle
  // on behalf of nobody.
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_write      = gnt0 & m0_write;
    if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign mem_chipselect = gnt_valid;
  assign mem_clken      = 1'b1;

  // Read tracking: a write wins over a simultaneous read on the same port.
  rd_tag_t rd_tag_d;
  rd_tag_t rd_pipe_q [RD_LAT];
  rd_tag_t rd_exit;

  always_comb begin
    rd_tag_d       = '0;
    rd_tag_d.valid = gnt_valid & ~mem_write;
    rd_tag_d.id    = gnt_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rd_pipe_q[i] <= '0;
      end
    end else begin
      rd_pipe_q[0] <= rd_tag_d;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  assign rd_exit          = rd_pipe_q[RD_LAT-1];
  assign m0_readdatavalid = rd_exit.valid && (rd_exit.id == M0);
  assign m1_readdatavalid = rd_exit.valid && (rd_exit.id == M1);

  logic [DATA_W-1:0] rdata;

`ifdef ONCHIP_ARB_OUTREG_EN
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_readdata;
    end
  end

  assign rdata = rdata_q;
`else
  assign rdata = mem_readdata;
`endif

  assign m0_readdata = rdata;
  assign m1_readdata = rdata;

`ifndef SYNTHESIS
  // Read and write together on one port is illegal; it is served as a write.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(m0_read && m0_write));
      assert (!(m1_read && m1_write));
    end
  end
`endif

endmodule
